// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a core req/gnt/rvalid handshake into APB SETUP/ACCESS transfers,
// one transfer in flight, with slave wait states, PSLVERR and an ACCESS-phase watchdog.
//
// state  | meaning
// IDLE   | no transfer; gnt_o follows req_i, request fields latched on grant
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or watchdog expiry
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic        WDOG_EN   = (TIMEOUT_CYCLES != 0);
    // Counter holds the number of ACCESS cycles already completed, so the N-th cycle sees N-1.
    localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'hFFFF;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wdog_cnt;
    logic        launch;
    logic        xfer_done;
    logic        wdog_expire;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_o       = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        launch      = 1'b0;
        xfer_done   = 1'b0;
        wdog_expire = 1'b0;
        case (state)
            IDLE: begin
                gnt_o  = req_i;
                launch = req_i;
                if (req_i) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A ready slave on the final watchdog cycle still completes normally.
                if (PREADY) begin
                    xfer_done = 1'b1;
                    state_nxt = IDLE;
                end else if (WDOG_EN && (wdog_cnt == WDOG_LAST)) begin
                    wdog_expire = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            wdog_cnt  <= '0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            rvalid_o  <= xfer_done | wdog_expire;
            timeout_o <= wdog_expire;

            if (launch) begin
                PADDR    <= addr_i;
                PWDATA   <= wdata_i;
                PWRITE   <= we_i;
                wdog_cnt <= '0;
            end else if (state == ACCESS) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end

            if (xfer_done) begin
                rdata_o <= PWRITE ? 32'd0 : PRDATA;
                err_o   <= PSLVERR;
            end else if (wdog_expire) begin
                rdata_o <= 32'd0;
                err_o   <= 1'b1;
            end
        end
    end

endmodule
